// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised raster timing generator (pixel-enable driven)
// Rev 1.0 - initial release, successor to the fixed 800x600 counter
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int HW        = 11,
  parameter int VW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          sync_clear,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    h_region,
  output logic [1:0]    v_region,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW1     = HW + 1;
  localparam int VW1     = VW + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Region boundaries carry one extra bit so an end equal to 2**HW cannot alias to 0.
  localparam logic [HW:0] H_END_VIS   = HW1'(H_VISIBLE);
  localparam logic [HW:0] H_END_FRONT = HW1'(H_VISIBLE + H_FRONT);
  localparam logic [HW:0] H_END_SYNC  = HW1'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW:0] V_END_VIS   = VW1'(V_VISIBLE);
  localparam logic [VW:0] V_END_FRONT = VW1'(V_VISIBLE + V_FRONT);
  localparam logic [VW:0] V_END_SYNC  = VW1'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [1:0] REG_VIS   = 2'd0;
  localparam logic [1:0] REG_FRONT = 2'd1;
  localparam logic [1:0] REG_SYNC  = 2'd2;
  localparam logic [1:0] REG_BACK  = 2'd3;

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  function automatic logic [1:0] h_decode(input logic [HW-1:0] h);
    logic [HW:0] x;
    x = {1'b0, h};
    if (x < H_END_VIS)        return REG_VIS;
    else if (x < H_END_FRONT) return REG_FRONT;
    else if (x < H_END_SYNC)  return REG_SYNC;
    else                      return REG_BACK;
  endfunction

  function automatic logic [1:0] v_decode(input logic [VW-1:0] v);
    logic [VW:0] x;
    x = {1'b0, v};
    if (x < V_END_VIS)        return REG_VIS;
    else if (x < V_END_FRONT) return REG_FRONT;
    else if (x < V_END_SYNC)  return REG_SYNC;
    else                      return REG_BACK;
  endfunction

  logic [HW-1:0] h_load;
  logic [VW-1:0] v_load;
  logic [1:0]    h_reg_load;
  logic [1:0]    v_reg_load;

  // Value the counters take on a loading edge; flags are decoded from it so
  // they line up with the exported counters without extra latency.
  always_comb begin
    h_load = '0;
    v_load = '0;
    if (!sync_clear) begin
      if (hcount == H_LAST) begin
        v_load = (vcount == V_LAST) ? '0 : vcount + VW'(1);
      end else begin
        h_load = hcount + HW'(1);
        v_load = vcount;
      end
    end
    h_reg_load = h_decode(h_load);
    v_reg_load = v_decode(v_load);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      h_region    <= REG_VIS;
      v_region    <= REG_VIS;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (sync_clear || pix_en) begin
      hcount      <= h_load;
      vcount      <= v_load;
      hsync       <= (h_reg_load == REG_SYNC) ? HS_ON : ~HS_ON;
      vsync       <= (v_reg_load == REG_SYNC) ? VS_ON : ~VS_ON;
      h_region    <= h_reg_load;
      v_region    <= v_reg_load;
      display_on  <= (h_reg_load == REG_VIS) && (v_reg_load == REG_VIS);
      line_start  <= (h_load == '0);
      frame_start <= (h_load == '0) && (v_load == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Self-checking bench for vga_timing_gen: small-raster instances against an
// arithmetic raster model, plus a wide-line instance and the default timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_en = 1'b0;
  logic sync_clear = 1'b0;
  always #5 clk = ~clk;

  // s: small raster, active-high syncs; n: same raster, active-low syncs
  logic [3:0] s_hc;  logic [2:0] s_vc;  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [1:0] s_hr, s_vr;
  logic [3:0] n_hc;  logic [2:0] n_vc;  logic n_hs, n_vs, n_de, n_ls, n_fs;
  logic [1:0] n_hr, n_vr;
  // w: default line timing with a short frame; d: full default timing
  logic [10:0] w_hc; logic [3:0] w_vc;  logic w_hs, w_vs, w_de, w_ls, w_fs;
  logic [1:0] w_hr, w_vr;
  logic [10:0] d_hc; logic [9:0] d_vc;  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [1:0] d_hr, d_vr;

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .HSYNC_POL(1), .VSYNC_POL(1), .HW(4), .VW(3)) u_s (
    .clk(clk), .reset(reset), .pix_en(pix_en), .sync_clear(sync_clear),
    .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .h_region(s_hr), .v_region(s_vr), .display_on(s_de),
    .line_start(s_ls), .frame_start(s_fs));

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .HSYNC_POL(0), .VSYNC_POL(0), .HW(4), .VW(3)) u_n (
    .clk(clk), .reset(reset), .pix_en(pix_en), .sync_clear(sync_clear),
    .hcount(n_hc), .vcount(n_vc), .hsync(n_hs), .vsync(n_vs),
    .h_region(n_hr), .v_region(n_vr), .display_on(n_de),
    .line_start(n_ls), .frame_start(n_fs));

  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(4), .V_BACK(1), .VW(4)) u_w (
    .clk(clk), .reset(reset), .pix_en(pix_en), .sync_clear(sync_clear),
    .hcount(w_hc), .vcount(w_vc), .hsync(w_hs), .vsync(w_vs),
    .h_region(w_hr), .v_region(w_vr), .display_on(w_de),
    .line_start(w_ls), .frame_start(w_fs));

  vga_timing_gen u_d (
    .clk(clk), .reset(reset), .pix_en(pix_en), .sync_clear(sync_clear),
    .hcount(d_hc), .vcount(d_vc), .hsync(d_hs), .vsync(d_vs),
    .h_region(d_hr), .v_region(d_vr), .display_on(d_de),
    .line_start(d_ls), .frame_start(d_fs));

  int total = 0;
  int bad = 0;

  // Model: pos counts raster positions loaded since reset/clear.
  int pos = 0;
  bit decoded = 1'b0;
  bit loaded = 1'b0;
  logic [3:0] e_h; logic [2:0] e_v; logic [1:0] e_hr, e_vr;
  logic e_hs, e_vs, e_de, e_ls, e_fs, e_nhs, e_nvs;

  function automatic logic [1:0] region_of(int x, int l0, int l1, int l2);
    int lens[3];
    int bound;
    lens = '{l0, l1, l2};
    bound = 0;
    for (int r = 0; r < 3; r++) begin
      bound += lens[r];
      if (x < bound) return 2'(r);
    end
    return 2'd3;
  endfunction

  task automatic update_expect();
    int h, v;
    h = pos % 16;
    v = (pos / 16) % 8;
    e_h = 4'(h);
    e_v = 3'(v);
    if (!decoded) begin
      e_hr = 2'd0; e_vr = 2'd0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
      e_ls = 1'b0; e_fs = 1'b0; e_nhs = 1'b1; e_nvs = 1'b1;
    end else begin
      e_hr = region_of(h, 8, 2, 3);
      e_vr = region_of(v, 4, 1, 2);
      e_hs = (e_hr == 2'd2);
      e_vs = (e_vr == 2'd2);
      e_de = (e_hr == 2'd0) && (e_vr == 2'd0);
      e_ls = loaded && (h == 0);
      e_fs = loaded && (h == 0) && (v == 0);
      e_nhs = !e_hs;
      e_nvs = !e_vs;
    end
  endtask

  task automatic tick(input logic en, input logic clr);
    @(negedge clk);
    pix_en = en;
    sync_clear = clr;
    @(posedge clk);
    if (clr) begin pos = 0; decoded = 1'b1; loaded = 1'b1; end
    else if (en) begin pos++; decoded = 1'b1; loaded = 1'b1; end
    else loaded = 1'b0;
    update_expect();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; pix_en = 1'b0; sync_clear = 1'b0;
    pos = 0; decoded = 1'b0; loaded = 1'b0;
    update_expect();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (s_hc !== 4'd0) begin bad++; $display("FAIL rst_hcount got=%0d exp=0", s_hc); end
    total++; if (s_vc !== 3'd0) begin bad++; $display("FAIL rst_vcount got=%0d exp=0", s_vc); end
    total++; if (s_hs !== 1'b0) begin bad++; $display("FAIL rst_hsync got=%b exp=0", s_hs); end
    total++; if (s_vs !== 1'b0) begin bad++; $display("FAIL rst_vsync got=%b exp=0", s_vs); end
    total++; if (s_hr !== 2'd0 || s_vr !== 2'd0) begin bad++; $display("FAIL rst_region got=%0d/%0d exp=0/0", s_hr, s_vr); end
    total++; if (s_de !== 1'b0) begin bad++; $display("FAIL rst_display got=%b exp=0", s_de); end
    total++; if (s_ls !== 1'b0 || s_fs !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", s_ls, s_fs); end
    total++; if (n_hs !== 1'b1 || n_vs !== 1'b1) begin bad++; $display("FAIL rst_neg_sync got=%b%b exp=11", n_hs, n_vs); end
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    total++; if (s_hc !== 4'd0 || s_de !== 1'b0 || s_ls !== 1'b0 || s_fs !== 1'b0)
      begin bad++; $display("FAIL idle_after_release got hc=%0d de=%b ls=%b fs=%b exp 0 0 0 0", s_hc, s_de, s_ls, s_fs); end
  endtask

  task automatic test_continuous();
    int last_fs;
    last_fs = -1;
    for (int i = 1; i <= 300; i++) begin
      tick(1'b1, 1'b0);
      total++; if (s_hc !== e_h || s_vc !== e_v) begin bad++; $display("FAIL cont_count got=%0d,%0d exp=%0d,%0d", s_hc, s_vc, e_h, e_v); end
      total++; if (s_hr !== e_hr || s_vr !== e_vr) begin bad++; $display("FAIL cont_region got=%0d/%0d exp=%0d/%0d", s_hr, s_vr, e_hr, e_vr); end
      total++; if (s_hs !== e_hs || s_vs !== e_vs) begin bad++; $display("FAIL cont_sync got=%b%b exp=%b%b", s_hs, s_vs, e_hs, e_vs); end
      total++; if (n_hs !== e_nhs || n_vs !== e_nvs) begin bad++; $display("FAIL cont_neg_sync got=%b%b exp=%b%b", n_hs, n_vs, e_nhs, e_nvs); end
      total++; if (s_de !== e_de) begin bad++; $display("FAIL cont_display got=%b exp=%b at %0d,%0d", s_de, e_de, e_h, e_v); end
      total++; if (s_ls !== e_ls || s_fs !== e_fs) begin bad++; $display("FAIL cont_strobes got=%b%b exp=%b%b", s_ls, s_fs, e_ls, e_fs); end
      if (s_fs === 1'b1) begin
        if (last_fs >= 0) begin
          total++; if (i - last_fs != 128) begin bad++; $display("FAIL frame_period got=%0d exp=128", i - last_fs); end
        end
        last_fs = i;
      end
    end
    total++; if (last_fs != 256) begin bad++; $display("FAIL last_frame_start got=%0d exp=256", last_fs); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 200 && !(e_h == 4'd5 && e_v == 3'd6); k++) tick(1'b1, 1'b0);
    total++; if (s_hc !== 4'd5 || s_vc !== 3'd6) begin bad++; $display("FAIL seek_5_6 got=%0d,%0d exp=5,6", s_hc, s_vc); end
    #2 reset = 1'b0;
    #1;
    total++; if (s_hc !== 4'd0 || s_vc !== 3'd0) begin bad++; $display("FAIL async_rst_count got=%0d,%0d exp=0,0", s_hc, s_vc); end
    total++; if (s_de !== 1'b0 || s_hr !== 2'd0 || s_vr !== 2'd0) begin bad++; $display("FAIL async_rst_flags got de=%b hr=%0d vr=%0d exp 0", s_de, s_hr, s_vr); end
    total++; if (s_vs !== 1'b0 || n_vs !== 1'b1 || n_hs !== 1'b1) begin bad++; $display("FAIL async_rst_sync got=%b%b%b exp=011", s_vs, n_vs, n_hs); end
    pos = 0; decoded = 1'b0; loaded = 1'b0; pix_en = 1'b0;
    update_expect();
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, 1'b0);
    total++; if (s_hc !== 4'd1 || s_vc !== 3'd0) begin bad++; $display("FAIL post_rst_first got=%0d,%0d exp=1,0", s_hc, s_vc); end
    total++; if (s_de !== 1'b1 || s_ls !== 1'b0) begin bad++; $display("FAIL post_rst_flags got de=%b ls=%b exp 1 0", s_de, s_ls); end
  endtask

  task automatic test_sparse_enable();
    int ls_cycles;
    ls_cycles = 0;
    for (int i = 0; i < 560; i++) begin
      tick(i % 4 == 0, 1'b0);
      if (s_ls === 1'b1) ls_cycles++;
      total++; if (s_hc !== e_h || s_vc !== e_v) begin bad++; $display("FAIL sparse_count got=%0d,%0d exp=%0d,%0d", s_hc, s_vc, e_h, e_v); end
      total++; if (s_hs !== e_hs || s_vs !== e_vs || s_de !== e_de) begin bad++; $display("FAIL sparse_flags got=%b%b%b exp=%b%b%b", s_hs, s_vs, s_de, e_hs, e_vs, e_de); end
      total++; if (s_ls !== e_ls || s_fs !== e_fs) begin bad++; $display("FAIL sparse_strobes got=%b%b exp=%b%b", s_ls, s_fs, e_ls, e_fs); end
    end
    // 140 enabled steps from position 1 cross line starts at 16,32,...,128
    total++; if (ls_cycles != 8) begin bad++; $display("FAIL sparse_ls_width got=%0d exp=8", ls_cycles); end
  endtask

  task automatic test_sync_clear();
    for (int k = 0; k < 200 && !(e_h == 4'd9 && e_v == 3'd2); k++) tick(1'b1, 1'b0);
    total++; if (s_hc !== 4'd9 || s_vc !== 3'd2) begin bad++; $display("FAIL seek_9_2 got=%0d,%0d exp=9,2", s_hc, s_vc); end
    tick(1'b0, 1'b1);
    total++; if (s_hc !== 4'd0 || s_vc !== 3'd0) begin bad++; $display("FAIL clr_count got=%0d,%0d exp=0,0", s_hc, s_vc); end
    total++; if (s_fs !== 1'b1 || s_ls !== 1'b1) begin bad++; $display("FAIL clr_strobes got=%b%b exp=11", s_fs, s_ls); end
    total++; if (s_de !== 1'b1) begin bad++; $display("FAIL clr_display got=%b exp=1", s_de); end
    tick(1'b0, 1'b0);
    total++; if (s_fs !== 1'b0 || s_hc !== 4'd0 || s_de !== 1'b1) begin bad++; $display("FAIL clr_hold got fs=%b hc=%0d de=%b exp 0 0 1", s_fs, s_hc, s_de); end
  endtask

  task automatic test_random();
    logic en, clr;
    for (int i = 0; i < 800; i++) begin
      en = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      tick(en, clr);
      total++; if (s_hc !== e_h || s_vc !== e_v) begin bad++; $display("FAIL rand_count got=%0d,%0d exp=%0d,%0d", s_hc, s_vc, e_h, e_v); end
      total++; if (s_hr !== e_hr || s_vr !== e_vr || s_de !== e_de) begin bad++; $display("FAIL rand_region got=%0d/%0d/%b exp=%0d/%0d/%b", s_hr, s_vr, s_de, e_hr, e_vr, e_de); end
      total++; if (s_hs !== e_hs || s_vs !== e_vs || n_hs !== e_nhs || n_vs !== e_nvs) begin bad++; $display("FAIL rand_sync got=%b%b%b%b exp=%b%b%b%b", s_hs, s_vs, n_hs, n_vs, e_hs, e_vs, e_nhs, e_nvs); end
      total++; if (s_ls !== e_ls || s_fs !== e_fs) begin bad++; $display("FAIL rand_strobes got=%b%b exp=%b%b", s_ls, s_fs, e_ls, e_fs); end
    end
  endtask

  task automatic test_default_frame();
    int w_ls_n, w_de_n, w_vs_n, d_ls_n, d_de_n, m_d_ls, m_d_de, p, dh, dv;
    logic prev_vs;
    w_ls_n = 0; w_de_n = 0; w_vs_n = 0; d_ls_n = 0; d_de_n = 0; m_d_ls = 0; m_d_de = 0;
    do_reset();
    prev_vs = w_vs;
    for (int i = 1; i <= 10560; i++) begin
      tick(1'b1, 1'b0);
      p = i;
      dh = p % 1056;
      dv = (p / 1056) % 628;
      if (dh == 0) m_d_ls++;
      if (region_of(dh, 800, 40, 128) == 2'd0 && region_of(dv, 600, 1, 4) == 2'd0) m_d_de++;
      w_ls_n += int'(w_ls); w_de_n += int'(w_de); w_vs_n += int'(w_vs);
      d_ls_n += int'(d_ls); d_de_n += int'(d_de);
      total++; if (w_hc !== 11'(p % 1056) || w_vc !== 4'(dv % 10)) begin bad++; $display("FAIL wide_count got=%0d,%0d exp=%0d,%0d", w_hc, w_vc, p % 1056, dv % 10); end
      total++; if (d_hc !== 11'(dh) || d_vc !== 10'(dv)) begin bad++; $display("FAIL dflt_count got=%0d,%0d exp=%0d,%0d", d_hc, d_vc, dh, dv); end
      if (w_vs !== prev_vs) begin
        total++; if (w_hc !== 11'd0) begin bad++; $display("FAIL vsync_edge_hcount got=%0d exp=0", w_hc); end
      end
      prev_vs = w_vs;
    end
    total++; if (w_ls_n != 10) begin bad++; $display("FAIL wide_line_starts got=%0d exp=10", w_ls_n); end
    total++; if (w_de_n != 3200) begin bad++; $display("FAIL wide_display got=%0d exp=3200", w_de_n); end
    total++; if (w_vs_n != 4224) begin bad++; $display("FAIL wide_vsync_width got=%0d exp=4224", w_vs_n); end
    total++; if (d_ls_n != m_d_ls) begin bad++; $display("FAIL dflt_line_starts got=%0d exp=%0d", d_ls_n, m_d_ls); end
    total++; if (d_de_n != m_d_de) begin bad++; $display("FAIL dflt_display got=%0d exp=%0d", d_de_n, m_d_de); end
  endtask

  initial begin
    update_expect();
    test_reset();
    test_continuous();
    test_async_reset();
    test_sparse_enable();
    test_sync_clear();
    test_random();
    test_default_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
